// File: rtl/ex_stage_pipe.sv
// Execute stage sitting between ID/EX and MEM. Single-cycle ALU ops plus an
// iterative shift-add multiplier, with valid/ready handshakes on both sides,
// output backpressure and a synchronous flush. The output registers form the
// EX/MEM pipeline register.
module ex_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 5,
  parameter int RD_W   = 5,
  parameter int MUL_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_op,
  input  logic              alu_src,
  input  logic [CTRL_W-1:0] ctrl_ex,
  input  logic [RD_W-1:0]   rd_ex,
  input  logic [XLEN-1:0]   r_data1,
  input  logic [XLEN-1:0]   r_data2,
  input  logic [XLEN-1:0]   extended,
  input  logic [XLEN-1:0]   pc4_ex,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_mem,
  output logic [RD_W-1:0]   rd_mem,
  output logic [XLEN-1:0]   alu_result,
  output logic [XLEN-1:0]   write_data1,
  output logic [XLEN-1:0]   pc4_mem,
  output logic              busy
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [SH_W-1:0] CNT_LAST = SH_W'(XLEN - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  logic [0:0]        state;
  logic [SH_W-1:0]   cnt;
  logic [XLEN-1:0]   operand_b;
  logic [SH_W-1:0]   shamt;
  logic [XLEN-1:0]   alu_value;
  logic              accept;
  logic              is_mul;
  logic              mul_done;
  logic [XLEN-1:0]   mul_a;
  logic [XLEN-1:0]   mul_b;
  logic [XLEN-1:0]   mul_acc;
  logic [XLEN-1:0]   mul_sum;
  logic [CTRL_W-1:0] hold_ctrl;
  logic [RD_W-1:0]   hold_rd;
  logic [XLEN-1:0]   hold_rdata2;
  logic [XLEN-1:0]   hold_pc4;

  assign operand_b = alu_src ? extended : r_data2;
  assign shamt     = operand_b[SH_W-1:0];

  // A new op is only taken when idle and the output slot is free or draining.
  assign in_ready = !reset && !flush && (state == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (MUL_EN != 0) && (alu_op == OP_MUL);
  assign busy     = (MUL_EN != 0) && (state == S_MUL);
  assign mul_done = (state == S_MUL) && (cnt == CNT_LAST);
  assign mul_sum  = mul_acc + (mul_b[0] ? mul_a : '0);

  // Single-cycle ALU; MUL (when disabled) and unused opcodes produce zero.
  always_comb begin
    alu_value = '0;
    case (alu_op)
      OP_ADD:  alu_value = r_data1 + operand_b;
      OP_SUB:  alu_value = r_data1 - operand_b;
      OP_AND:  alu_value = r_data1 & operand_b;
      OP_OR:   alu_value = r_data1 | operand_b;
      OP_SLL:  alu_value = r_data1 << shamt;
      OP_SLT:  alu_value = {{(XLEN-1){1'b0}}, ($signed(r_data1) < $signed(operand_b))};
      OP_XOR:  alu_value = r_data1 ^ operand_b;
      OP_SRL:  alu_value = r_data1 >> shamt;
      OP_SRA:  alu_value = $signed(r_data1) >>> shamt;
      OP_SLTU: alu_value = {{(XLEN-1){1'b0}}, (r_data1 < operand_b)};
      default: alu_value = '0;
    endcase
  end

  // Control FSM and iteration counter: IDLE accepts, MUL runs XLEN steps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && is_mul) begin
            state <= S_MUL;
            cnt   <= '0;
          end
        end
        S_MUL: begin
          if (cnt == CNT_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + SH_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Multiplier datapath: capture operands and sideband, then shift-add one bit per edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_a       <= '0;
      mul_b       <= '0;
      mul_acc     <= '0;
      hold_ctrl   <= '0;
      hold_rd     <= '0;
      hold_rdata2 <= '0;
      hold_pc4    <= '0;
    end else if (!flush) begin
      if (accept && is_mul) begin
        mul_a       <= r_data1;
        mul_b       <= operand_b;
        mul_acc     <= '0;
        hold_ctrl   <= ctrl_ex;
        hold_rd     <= rd_ex;
        hold_rdata2 <= r_data2;
        hold_pc4    <= pc4_ex;
      end else if (state == S_MUL) begin
        mul_acc <= mul_sum;
        mul_a   <= mul_a << 1;
        mul_b   <= mul_b >> 1;
      end
    end
  end

  // EX/MEM register: loads on a finished MUL or a non-MUL accept, drains on out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      ctrl_mem    <= '0;
      rd_mem      <= '0;
      alu_result  <= '0;
      write_data1 <= '0;
      pc4_mem     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (mul_done) begin
      out_valid   <= 1'b1;
      ctrl_mem    <= hold_ctrl;
      rd_mem      <= hold_rd;
      alu_result  <= mul_sum;
      write_data1 <= hold_rdata2;
      pc4_mem     <= hold_pc4;
    end else if (accept && !is_mul) begin
      out_valid   <= 1'b1;
      ctrl_mem    <= ctrl_ex;
      rd_mem      <= rd_ex;
      alu_result  <= alu_value;
      write_data1 <= r_data2;
      pc4_mem     <= pc4_ex;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Self-checking bench for ex_stage_pipe: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_ex_stage_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic [4:0]  ctrl_ex;
  logic [4:0]  rd_ex;
  logic [31:0] r_data1;
  logic [31:0] r_data2;
  logic [31:0] extended;
  logic [31:0] pc4_ex;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  ctrl_mem;
  logic [4:0]  rd_mem;
  logic [31:0] alu_result;
  logic [31:0] write_data1;
  logic [31:0] pc4_mem;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: output slot contents plus a countdown for an in-flight multiply.
  logic        m_ov;
  logic [31:0] m_res, m_wd, m_pc4;
  logic [4:0]  m_ctrl, m_rd;
  int          m_left;
  logic [31:0] p_res, p_wd, p_pc4;
  logic [4:0]  p_ctrl, p_rd;

  ex_stage_pipe #(.XLEN(32), .CTRL_W(5), .RD_W(5), .MUL_EN(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_src(alu_src), .ctrl_ex(ctrl_ex), .rd_ex(rd_ex),
    .r_data1(r_data1), .r_data2(r_data2), .extended(extended), .pc4_ex(pc4_ex),
    .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_mem(ctrl_mem), .rd_mem(rd_mem), .alu_result(alu_result),
    .write_data1(write_data1), .pc4_mem(pc4_mem), .busy(busy)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Architectural result of each opcode, computed from plain arithmetic.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [63:0] wide;
    sh = b % 32;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a << sh;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return a ^ b;
      4'd7:  return a >> sh;
      4'd8:  begin
        wide = {{32{a[31]}}, a} >> sh;
        return wide[31:0];
      end
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: begin
        wide = {32'd0, a} * {32'd0, b};
        return wide[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_ready();
    return !reset && !flush && (m_left == 0) && (!m_ov || out_ready);
  endfunction

  task automatic modelReset();
    m_ov = 1'b0; m_res = '0; m_wd = '0; m_pc4 = '0; m_ctrl = '0; m_rd = '0;
    m_left = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic modelStep();
    logic [31:0] b;
    b = alu_src ? extended : r_data2;
    if (reset) begin
      modelReset();
    end else if (flush) begin
      m_ov = 1'b0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_ov = 1'b1; m_res = p_res; m_wd = p_wd; m_pc4 = p_pc4; m_ctrl = p_ctrl; m_rd = p_rd;
      end
    end else if (in_valid && exp_ready()) begin
      if (alu_op == 4'd10) begin
        m_left = 32;
        m_ov = 1'b0;
        p_res = alu_ref(alu_op, r_data1, b);
        p_wd = r_data2; p_pc4 = pc4_ex; p_ctrl = ctrl_ex; p_rd = rd_ex;
      end else begin
        m_ov = 1'b1;
        m_res = alu_ref(alu_op, r_data1, b);
        m_wd = r_data2; m_pc4 = pc4_ex; m_ctrl = ctrl_ex; m_rd = rd_ex;
      end
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
  endtask

  // Counts one comparison and reports it when the observed value differs.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("out_valid", 64'(out_valid), 64'(m_ov));
    checkOutput("busy", 64'(busy), 64'(m_left > 0));
    checkOutput("alu_result", 64'(alu_result), 64'(m_res));
    checkOutput("write_data1", 64'(write_data1), 64'(m_wd));
    checkOutput("pc4_mem", 64'(pc4_mem), 64'(m_pc4));
    checkOutput("ctrl_mem", 64'(ctrl_mem), 64'(m_ctrl));
    checkOutput("rd_mem", 64'(rd_mem), 64'(m_rd));
  endtask

  // Drive one cycle of inputs from a negedge, step the model at the edge, check at the next negedge.
  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic src,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] ext,
                               input logic fl, input logic ordy);
    in_valid = v; alu_op = op; alu_src = src;
    r_data1 = a; r_data2 = b; extended = ext;
    flush = fl; out_ready = ordy;
    ctrl_ex = 5'($urandom); rd_ex = 5'($urandom); pc4_ex = $urandom;
    #1;
    checkOutput("in_ready", 64'(in_ready), 64'(exp_ready()));
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  // Directed scenarios, then random traffic.
  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = '0; alu_src = 1'b0; ctrl_ex = '0; rd_ex = '0;
    r_data1 = '0; r_data2 = '0; extended = '0; pc4_ex = '0;
    modelReset();
    p_res = '0; p_wd = '0; p_pc4 = '0; p_ctrl = '0; p_rd = '0;
    @(negedge clk);
    checkAll();
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;

    $display("[TB] reset during multiply");
    applyStimulus(1, 4'd10, 0, 32'd7, 32'd9, 32'd0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 4'd0, 0, $urandom, $urandom, $urandom, 0, 1);
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_mid_busy", 64'(busy), 64'd0);
    checkOutput("rst_mid_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_mid_alu_result", 64'(alu_result), 64'd0);
    checkOutput("rst_mid_ctrl_mem", 64'(ctrl_mem), 64'd0);
    checkOutput("rst_mid_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    checkAll();
    reset = 1'b0;

    $display("[TB] add immediate");
    applyStimulus(1, 4'd0, 1, 32'd5, 32'h0000_1234, 32'hFFFF_FFFF, 0, 1);
    checkOutput("add_imm_result", 64'(alu_result), 64'h4);
    checkOutput("add_imm_valid", 64'(out_valid), 64'd1);
    checkOutput("add_imm_wdata", 64'(write_data1), 64'h1234);

    $display("[TB] compare and shift");
    applyStimulus(1, 4'd5, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1);
    checkOutput("slt_const", 64'(alu_result), 64'd1);
    applyStimulus(1, 4'd9, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1);
    checkOutput("sltu_const", 64'(alu_result), 64'd0);
    applyStimulus(1, 4'd8, 0, 32'h8000_0000, 32'd4, 32'd0, 0, 1);
    checkOutput("sra_const", 64'(alu_result), 64'hF800_0000);
    applyStimulus(1, 4'd7, 0, 32'h8000_0000, 32'd4, 32'd0, 0, 1);
    checkOutput("srl_const", 64'(alu_result), 64'h0800_0000);
    applyStimulus(1, 4'd4, 1, 32'd1, 32'd0, 32'd33, 0, 1);
    checkOutput("sll_const", 64'(alu_result), 64'h2);

    $display("[TB] iterative multiply");
    applyStimulus(1, 4'd10, 0, 32'd7, 32'hFFFF_FFFF, 32'd0, 0, 1);
    for (int i = 0; i < 32; i++) applyStimulus(1, 4'd0, 0, $urandom, $urandom, $urandom, 0, 1);
    checkOutput("mul_const", 64'(alu_result), 64'hFFFF_FFF9);
    checkOutput("mul_valid", 64'(out_valid), 64'd1);

    $display("[TB] backpressure");
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'd0, 0, $urandom, $urandom, $urandom, 0, 0);
    applyStimulus(1, 4'd0, 0, 32'd1, 32'd1, 32'd0, 0, 1);
    checkOutput("bp_add_const", 64'(alu_result), 64'd2);
    checkOutput("bp_valid", 64'(out_valid), 64'd1);

    $display("[TB] flush during multiply");
    applyStimulus(1, 4'd10, 0, $urandom, $urandom, 32'd0, 0, 1);
    for (int i = 0; i < 9; i++) applyStimulus(1, 4'd0, 0, $urandom, $urandom, $urandom, 0, 1);
    applyStimulus(1, 4'd0, 0, 32'd100, 32'd200, 32'd0, 1, 1);
    checkOutput("flush_busy", 64'(busy), 64'd0);
    checkOutput("flush_valid", 64'(out_valid), 64'd0);
    applyStimulus(1, 4'd0, 0, 32'd3, 32'd4, 32'd0, 0, 1);
    checkOutput("post_flush_add", 64'(alu_result), 64'd7);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
      applyStimulus(1'($urandom_range(0, 3) != 0), op, 1'($urandom),
                    $urandom, $urandom, $urandom,
                    1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 9) < 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
